// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a registered, time-multiplexed digit scanner
// for a common-anode display. Blanked digits are emitted as 4'hF.
module bcd_scan_counter #(
  parameter int unsigned CNT_DIV  = 50000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic [15:0] value,
  output logic        wrap
);

  localparam int unsigned CntW  = $clog2(CNT_DIV);
  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0]  CntLast  = CntW'(CNT_DIV - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  logic [CntW-1:0]  cnt_pre_q, cnt_pre_d;
  logic [ScanW-1:0] scan_pre_q, scan_pre_d;
  logic [15:0]      count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;

  logic             tick;
  logic [15:0]      step_val;
  logic             step_carry;
  logic [15:0]      load_clamped;
  logic [3:0]       lz;
  logic [3:0]       digit;

  assign tick = run & (cnt_pre_q == CntLast);

  // Ripple increment/decrement across digits; a carry surviving all four digits is a wrap.
  always_comb begin
    step_val   = count_q;
    step_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (step_carry) begin
        if (up) begin
          if (count_q[4*i +: 4] >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end
  end

  // Non-decimal nibbles in the load value are forced to zero.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < 4; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // Count and count-prescaler next state; load wins over a coincident tick.
  always_comb begin
    count_d   = count_q;
    cnt_pre_d = cnt_pre_q;
    wrap_d    = 1'b0;
    if (load) begin
      count_d   = load_clamped;
      cnt_pre_d = '0;
    end else if (run) begin
      if (tick) begin
        cnt_pre_d = '0;
        count_d   = step_val;
        wrap_d    = step_carry;
      end else begin
        cnt_pre_d = cnt_pre_q + CntW'(1);
      end
    end
  end

  // Free-running scan prescaler and digit index.
  always_comb begin
    scan_pre_d = scan_pre_q + ScanW'(1);
    idx_d      = idx_q;
    if (scan_pre_q == ScanLast) begin
      scan_pre_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Scanned digit with leading-zero blanking; lz[i] means digit i and all above are zero.
  always_comb begin
    lz[3] = (count_q[15:12] == 4'd0);
    lz[2] = lz[3] & (count_q[11:8] == 4'd0);
    lz[1] = lz[2] & (count_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    digit = count_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << idx_q);
    bcd_d = (blank_lz && lz[idx_q]) ? 4'hF : digit;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_pre_q  <= '0;
      scan_pre_q <= '0;
      count_q    <= 16'h0000;
      idx_q      <= 2'd0;
      wrap_q     <= 1'b0;
      an_q       <= 4'b1110;
      bcd_q      <= 4'h0;
    end else begin
      cnt_pre_q  <= cnt_pre_d;
      scan_pre_q <= scan_pre_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wrap_q     <= wrap_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
    end
  end

  assign value = count_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign bcd   = bcd_q;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Four-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the team's BCD-to-7-segment decoder. It drives the decoder's 4-bit bcd input one digit at a time, plus active-low anode selects for a common-anode 4-digit display.
- Blanked digits are output as code 4'hF, which the decoder renders as all segments off.

Parameters:
- CNT_DIV, default 50000000: clk cycles per count step while running; legal range 2 or more.
- SCAN_DIV, default 100000: clk cycles per digit-scan advance; legal range 2 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- run  input  1  1 = count prescaler advances; 0 = count and prescaler hold.
- up  input  1  count direction: 1 = increment, 0 = decrement; sampled on each count step.
- load  input  1  synchronous load strobe.
- load_val  input  16  four packed BCD digits, digit3 in [15:12] down to digit0 in [3:0].
- blank_lz  input  1  1 = suppress leading zeros.
- bcd  output  4  current scanned digit code; 4'hF = blank.
- an  output  4  active-low one-hot digit enable; an[i]=0 selects digit i.
- value  output  16  packed BCD count (digit3..digit0), registered.
- wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - count to 0000 and both prescalers to 0;
  - scan index to 0;
  - outputs to bcd=4'h0, an=4'b1110, value=16'h0000, wrap=0.
- Reset overrides every other input in the same cycle. Asserting reset mid-count or mid-scan returns all state to the reset values on that edge.
- Count prescaler:
  - While run=1 it counts 0..CNT_DIV-1 and wraps.
  - A count step (tick) occurs in the cycle the prescaler equals CNT_DIV-1.
  - While run=0 it holds its value and no tick occurs.
- Count step, up=1:
  - digit0+1; a digit of 9 becomes 0 and carries into the next digit.
  - 9999 -> 0000, with wrap=1 for exactly that one cycle.
- Count step, up=0:
  - digit0-1; a digit of 0 becomes 9 and borrows from the next digit.
  - 0000 -> 9999, with wrap=1 for exactly that one cycle.
- wrap is registered and asserts on the same edge as the value change.
- Load (load=1) has priority over a tick in the same cycle:
  - count <= load_val, except any nibble >9 is loaded as 0;
  - the count prescaler clears to 0;
  - no wrap is generated;
  - the tick coinciding with the load is discarded.
- value always equals the internal count register, so a count or load becomes visible on the next edge.
- Scan prescaler:
  - Free-running, independent of run and load.
  - Counts 0..SCAN_DIV-1; at SCAN_DIV-1 the scan index advances 0->1->2->3->0.
- Scan outputs are registered and updated every cycle from the current index and count, giving one-cycle latency:
  - an <= ~(1<<idx);
  - bcd <= digit[idx], or 4'hF if that digit is blanked.
- Blanking rule, applied when blank_lz=1:
  - Digit i (i = 3, 2, 1) is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - Example: 0040 shows [blank, blank, 4, 0].
- With blank_lz=0 no digit is blanked.
- Exactly one an bit is low at all times after reset. There are no illegal states: idx is 2 bits and every encoding is used.

Test Plan:
- Reset/hold:
  - Stimulus: CNT_DIV=4, SCAN_DIV=2; rst_n=0 for 2 cycles, then run=0 for 20 cycles.
  - Required: value=0000 throughout; an cycles 1110->1101->1011->0111 every 2 cycles; bcd=0 throughout; wrap never asserts.
- Up count and wrap:
  - Stimulus: load 9998, up=1, run=1.
  - Required: value=9999 after 4 cycles; value=0000 after 8 cycles, with wrap=1 for exactly one cycle; value=0001 after 12 cycles.
- Down borrow:
  - Stimulus: load 1000, up=0, run=1.
  - Required: after 4 cycles value=0999; then load 0000 and wait 4 cycles.
  - Required after the second load: value=9999 with a one-cycle wrap pulse.
- Load collision and clamp:
  - Stimulus: assert load with load_val=16'h12A4 in the same cycle the prescaler reaches CNT_DIV-1.
  - Required: value=1204, no increment, no wrap; next tick occurs 4 cycles later giving 1205.
- Leading-zero blanking:
  - Stimulus: load 0040, blank_lz=1.
  - Required: over one scan round, bcd for digits 0..3 = 0, 4, F, F.
  - Stimulus: set blank_lz=0.
  - Required: bcd = 0, 4, 0, 0; also with value 0000 and blank_lz=1, digit0 shows 0 and digits 1–3 show F.
- Mid-operation reset:
  - Stimulus: count at 0573 with idx=2; pulse rst_n=0 for one edge.
  - Required: next cycle value=0000, an=1110, bcd=0, wrap=0; counting resumes from 0000 with a full CNT_DIV period.
